// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer
//   Transmit side of an SR-latch control link. Accepts one set/reset command
//   at a time over valid/ready and turns it into a single S or R pulse of
//   PULSE_W cycles, then holds both drives idle for DEAD_W cycles before
//   accepting the next command. S and R are never asserted together.
//   q_model tracks the latch Q that the issued commands should have produced.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   req_valid  command valid
//   req_val    1 = set (S pulse), 0 = reset (R pulse); sampled at accept only
//   req_ready  high in IDLE (and out of reset); accept = req_valid & req_ready
//   s_out      set drive, polarity per ACT_LOW
//   r_out      reset drive, polarity per ACT_LOW
//   busy       high while pulsing or in dead time
//   done       one-cycle strobe when a command completes
//   q_model    expected latch Q after the last accepted command
module sr_drive_sequencer #(
  parameter int PULSE_W        = 4,
  parameter int DEAD_W         = 2,
  parameter bit ACT_LOW        = 1'b0,
  parameter bit SKIP_REDUNDANT = 1'b1,
  parameter bit INIT_Q         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic done,
  output logic q_model
);

  localparam logic       ASSERTED = ACT_LOW ? 1'b0 : 1'b1;
  localparam logic       IDLE_LVL = ~ASSERTED;
  // Counter counts down to zero, so load one less than the dwell length.
  localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
  localparam logic [7:0] DEAD_LD  = 8'((DEAD_W == 0) ? 0 : DEAD_W - 1);

  typedef enum logic [1:0] {IDLE, PULSE, DEAD} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       accept;

  // rst_n gates ready so nothing is accepted on the reset edge itself.
  assign req_ready = (state == IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      s_out   <= IDLE_LVL;
      r_out   <= IDLE_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
      q_model <= INIT_Q;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_model <= req_val;
            if (SKIP_REDUNDANT && (req_val == q_model)) begin
              // Latch already holds this value: complete without a pulse.
              done <= 1'b1;
            end else begin
              state <= PULSE;
              cnt   <= PULSE_LD;
              busy  <= 1'b1;
              // Exactly one drive asserted, chosen from the sampled value.
              s_out <= req_val ? ASSERTED : IDLE_LVL;
              r_out <= req_val ? IDLE_LVL : ASSERTED;
            end
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            s_out <= IDLE_LVL;
            r_out <= IDLE_LVL;
            if (DEAD_W == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DEAD;
              cnt   <= DEAD_LD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DEAD: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          s_out <= IDLE_LVL;
          r_out <= IDLE_LVL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
module tb_sr_drive_sequencer;

  typedef struct {
    logic q;
    int   sp;
    int   rp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: defaults (active-high, DEAD_W=2). dut1: DEAD_W=0, active-low.
  logic rst_n0 = 1'b0, req_valid0 = 1'b0, req_val0 = 1'b0;
  logic req_ready0, s0, r0, busy0, done0, q0;
  logic rst_n1 = 1'b0, req_valid1 = 1'b0, req_val1 = 1'b0;
  logic req_ready1, s1, r1, busy1, done1, q1;

  int errors = 0;
  int checks = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic tq0 = 1'b0, tq1 = 1'b0;
  int sc0 = 0, rc0 = 0, sc1 = 0, rc1 = 0;

  sr_drive_sequencer #(.PULSE_W(4), .DEAD_W(2), .ACT_LOW(1'b0),
                       .SKIP_REDUNDANT(1'b1), .INIT_Q(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .req_valid(req_valid0), .req_val(req_val0),
    .req_ready(req_ready0), .s_out(s0), .r_out(r0), .busy(busy0),
    .done(done0), .q_model(q0));

  sr_drive_sequencer #(.PULSE_W(4), .DEAD_W(0), .ACT_LOW(1'b1),
                       .SKIP_REDUNDANT(1'b1), .INIT_Q(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_val(req_val1),
    .req_ready(req_ready1), .s_out(s1), .r_out(r1), .busy(busy1),
    .done(done1), .q_model(q1));

  // Scoreboard monitors: count asserted cycles per drive, compare on done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n0) begin
      sc0 = 0; rc0 = 0;
    end else begin
      checks++;
      if (s0 && r0) begin
        errors++; $display("FAIL invariant0 s=%b r=%b both asserted", s0, r0);
      end
      if (s0) sc0++;
      if (r0) rc0++;
      if (done0) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++; $display("FAIL sb0_empty done seen with no expected command");
        end else begin
          e = sb0.pop_front();
          if (q0 !== e.q || sc0 != e.sp || rc0 != e.rp) begin
            errors++;
            $display("FAIL sb0 got q=%b s_cyc=%0d r_cyc=%0d exp q=%b s_cyc=%0d r_cyc=%0d",
                     q0, sc0, rc0, e.q, e.sp, e.rp);
          end
        end
        sc0 = 0; rc0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n1) begin
      sc1 = 0; rc1 = 0;
    end else begin
      checks++;
      if (!s1 && !r1) begin
        errors++; $display("FAIL invariant1 s=%b r=%b both asserted (active-low)", s1, r1);
      end
      if (!s1) sc1++;
      if (!r1) rc1++;
      if (done1) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++; $display("FAIL sb1_empty done seen with no expected command");
        end else begin
          e = sb1.pop_front();
          if (q1 !== e.q || sc1 != e.sp || rc1 != e.rp) begin
            errors++;
            $display("FAIL sb1 got q=%b s_cyc=%0d r_cyc=%0d exp q=%b s_cyc=%0d r_cyc=%0d",
                     q1, sc1, rc1, e.q, e.sp, e.rp);
          end
        end
        sc1 = 0; rc1 = 0;
      end
    end
  end

  function automatic exp_t mk_exp(input logic v, input logic cur);
    exp_t e;
    logic red;
    red  = (v === cur);
    e.q  = v;
    e.sp = (!red && v)  ? 4 : 0;
    e.rp = (!red && !v) ? 4 : 0;
    return e;
  endfunction

  // Drive one command on dut0 as soon as it is ready; returns in cycle k+1.
  task automatic issue0(input logic v);
    int n = 0;
    while (!req_ready0 && n < 100) begin @(negedge clk); n++; end
    if (!req_ready0) begin
      checks++; errors++; $display("FAIL issue0_timeout req_ready=%b exp 1", req_ready0);
    end
    req_valid0 = 1'b1; req_val0 = v;
    sb0.push_back(mk_exp(v, tq0)); tq0 = v;
    @(posedge clk); #1 req_valid0 = 1'b0;
  endtask

  task automatic wait_done0();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done0 && n < 50);
    checks++;
    if (!done0) begin
      errors++; $display("FAIL wait_done0 done=%b exp 1 within 50 cycles", done0);
    end
  endtask

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready0 !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low got %b exp 0", req_ready0);
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({s0, r0, q0, req_ready0, busy0, done0} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_state0 got s=%b r=%b q=%b rdy=%b busy=%b done=%b exp 0 0 0 1 0 0",
               s0, r0, q0, req_ready0, busy0, done0);
    end
    checks++;
    if ({s1, r1, q1, req_ready1, busy1, done1} !== 6'b110100) begin
      errors++;
      $display("FAIL reset_state1 got s=%b r=%b q=%b rdy=%b busy=%b done=%b exp 1 1 0 1 0 0",
               s1, r1, q1, req_ready1, busy1, done1);
    end
  endtask

  // Set pulse with cycle-exact timing, then reset back-to-back on done.
  task automatic test_set_then_reset();
    req_valid0 = 1'b1; req_val0 = 1'b1;
    sb0.push_back(mk_exp(1'b1, tq0)); tq0 = 1'b1;
    @(posedge clk); #1 req_valid0 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (s0 !== (c <= 4) || r0 !== 1'b0 || done0 !== (c == 7) || q0 !== 1'b1 ||
          busy0 !== (c <= 6) || req_ready0 !== (c == 7)) begin
        errors++;
        $display("FAIL set_cycle%0d got s=%b r=%b done=%b q=%b busy=%b rdy=%b", c,
                 s0, r0, done0, q0, busy0, req_ready0);
      end
    end
    req_valid0 = 1'b1; req_val0 = 1'b0;
    sb0.push_back(mk_exp(1'b0, tq0)); tq0 = 1'b0;
    @(posedge clk); #1 req_valid0 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (r0 !== (c <= 4) || s0 !== 1'b0 || done0 !== (c == 7) || q0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_reset_cycle%0d got s=%b r=%b done=%b q=%b", c, s0, r0, done0, q0);
      end
    end
  endtask

  task automatic test_redundant();
    issue0(1'b1);
    wait_done0();
    req_valid0 = 1'b1; req_val0 = 1'b1;
    sb0.push_back(mk_exp(1'b1, tq0)); tq0 = 1'b1;
    @(posedge clk); #1 req_valid0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (s0 !== 1'b0 || r0 !== 1'b0 || busy0 !== 1'b0 || done0 !== (c == 1) || q0 !== 1'b1) begin
        errors++;
        $display("FAIL redundant_cycle%0d got s=%b r=%b busy=%b done=%b q=%b", c,
                 s0, r0, busy0, done0, q0);
      end
    end
  endtask

  task automatic test_abort();
    issue0(1'b0);            // q_model 1 -> 0 first so the abort set is a real pulse
    wait_done0();
    issue0(1'b1);            // now in cycle 1 (first PULSE cycle)
    @(posedge clk); #1;      // cycle 2
    @(negedge clk);
    rst_n0 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s0 !== 1'b0 || r0 !== 1'b0 || busy0 !== 1'b0 || q0 !== 1'b0 || req_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL abort got s=%b r=%b busy=%b q=%b rdy=%b exp 0 0 0 0 0",
               s0, r0, busy0, q0, req_ready0);
    end
    @(negedge clk);
    rst_n0 = 1'b1;
    sb0.delete(); tq0 = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL abort_idle got rdy=%b busy=%b exp 1 0", req_ready0, busy0);
    end
    issue0(1'b1);
    wait_done0();
  endtask

  task automatic test_act_low_nodead();
    int n = 0, cyc = 0;
    req_valid1 = 1'b1; req_val1 = 1'b1;
    sb1.push_back(mk_exp(1'b1, tq1)); tq1 = 1'b1;
    @(posedge clk); #1 req_valid1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (s1 !== (c > 4) || r1 !== 1'b1 || done1 !== (c == 5) || q1 !== 1'b1) begin
        errors++;
        $display("FAIL actlow_cycle%0d got s=%b r=%b done=%b q=%b", c, s1, r1, done1, q1);
      end
    end
    // Random run: valid toggles freely, val changes while busy must be ignored.
    while (n < 1000 && cyc < 30000) begin
      req_valid1 = 1'($urandom_range(0, 1));
      req_val1   = 1'($urandom_range(0, 1));
      if (req_valid1 && req_ready1) begin
        sb1.push_back(mk_exp(req_val1, tq1)); tq1 = req_val1;
        n++;
      end
      @(negedge clk); cyc++;
    end
    req_valid1 = 1'b0;
    cyc = 0;
    while (sb1.size() != 0 && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (n != 1000 || sb1.size() != 0) begin
      errors++;
      $display("FAIL random_run got accepts=%0d pending=%0d exp 1000 0", n, sb1.size());
    end
  endtask

  initial begin
    test_reset();
    test_set_then_reset();
    test_redundant();
    test_abort();
    test_act_low_nodead();
    repeat (3) @(negedge clk);
    checks++;
    if (sb0.size() != 0) begin
      errors++; $display("FAIL sb0_pending got %0d exp 0", sb0.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
